// File: rtl/router_pkg.sv
// Shared constants and helpers for the router synchronizer.
package router_pkg;

   localparam int unsigned ROUTER_NUM_CH  = 3;
   localparam int unsigned ROUTER_TIMEOUT = 30;

   // Width of an address able to name n channels; never narrower than one bit.
   function automatic int unsigned addr_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/router_idle_timer.sv
// Per-channel idle counter: a one-cycle soft_reset pulse after TIMEOUT
// consecutive cycles of valid data that nobody reads.
module router_idle_timer #(
   parameter int unsigned TIMEOUT = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic vld,
   input  logic rd,
   output logic soft_reset
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_d;

   // A read on the terminal cycle takes the clear path, so no pulse is raised.
   always_comb begin
      cnt_d   = '0;
      pulse_d = 1'b0;
      if (vld && !rd) begin
         if (cnt_q == TERM) begin
            pulse_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         soft_reset <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         soft_reset <= pulse_d;
      end
   end

endmodule

// File: rtl/router_sync_n.sv
// Router synchronizer: latches the header address, steers the FIFO write
// enable, reports the active channel's full flag and times out idle channels.
module router_sync_n
   import router_pkg::*;
#(
   parameter int unsigned NUM_CH  = ROUTER_NUM_CH,
   parameter int unsigned ADDR_W  = addr_width(NUM_CH),
   parameter int unsigned TIMEOUT = ROUTER_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              detect_add,
   input  logic              write_enb_reg,
   input  logic [NUM_CH-1:0] read_enb,
   input  logic [NUM_CH-1:0] full,
   input  logic [NUM_CH-1:0] empty,
   output logic [NUM_CH-1:0] write_enb,
   output logic              fifo_full,
   output logic [NUM_CH-1:0] vld_out,
   output logic [NUM_CH-1:0] soft_reset,
   output logic              addr_err
);

   logic [ADDR_W-1:0] addr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
      end else if (detect_add) begin
         addr_q <= data_in;
      end
   end

   // An address matching no channel leaves addr_err and fifo_full high,
   // which stalls the write FSM until a valid header arrives.
   always_comb begin
      write_enb = '0;
      fifo_full = 1'b1;
      addr_err  = 1'b1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (addr_q == ADDR_W'(i)) begin
            write_enb[i] = write_enb_reg;
            fifo_full    = full[i];
            addr_err     = 1'b0;
         end
      end
   end

   assign vld_out = ~empty;

   for (genvar g = 0; g < NUM_CH; g++) begin : gen_timer
      router_idle_timer #(
         .TIMEOUT(TIMEOUT)
      ) u_timer (
         .clk        (clk),
         .reset      (reset),
         .vld        (vld_out[g]),
         .rd         (read_enb[g]),
         .soft_reset (soft_reset[g])
      );
   end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n: default 3-channel/30-cycle build plus a
// 5-channel/4-cycle build sharing clock and reset.
module tb_router_sync_n;

   logic clk = 1'b0;
   logic reset;

   // Default configuration
   logic [1:0] data_in;
   logic       detect_add, write_enb_reg;
   logic [2:0] read_enb, full, empty;
   logic [2:0] write_enb, vld_out, soft_reset;
   logic       fifo_full, addr_err;

   // NUM_CH=5, TIMEOUT=4 configuration
   logic [2:0] data_in_b;
   logic       detect_add_b, write_enb_reg_b;
   logic [4:0] read_enb_b, full_b, empty_b;
   logic [4:0] write_enb_b, vld_out_b, soft_reset_b;
   logic       fifo_full_b, addr_err_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   router_sync_n u_dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .detect_add    (detect_add),
      .write_enb_reg (write_enb_reg),
      .read_enb      (read_enb),
      .full          (full),
      .empty         (empty),
      .write_enb     (write_enb),
      .fifo_full     (fifo_full),
      .vld_out       (vld_out),
      .soft_reset    (soft_reset),
      .addr_err      (addr_err)
   );

   router_sync_n #(
      .NUM_CH  (5),
      .TIMEOUT (4)
   ) u_dut_b (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in_b),
      .detect_add    (detect_add_b),
      .write_enb_reg (write_enb_reg_b),
      .read_enb      (read_enb_b),
      .full          (full_b),
      .empty         (empty_b),
      .write_enb     (write_enb_b),
      .fifo_full     (fifo_full_b),
      .vld_out       (vld_out_b),
      .soft_reset    (soft_reset_b),
      .addr_err      (addr_err_b)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; outputs are sampled 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] exp_we;
      logic       exp_err, exp_ff;

      reset = 1'b1;
      data_in = '0; detect_add = 1'b0; write_enb_reg = 1'b0;
      read_enb = '0; full = '0; empty = '1;
      data_in_b = '0; detect_add_b = 1'b0; write_enb_reg_b = 1'b0;
      read_enb_b = '0; full_b = '0; empty_b = '1;

      // Reset state; combinational paths stay live during reset
      #2;
      write_enb_reg = 1'b1;
      empty = 3'b101;
      #1;
      chk("rst_soft_reset", {5'b0, soft_reset}, 8'h00);
      chk("rst_write_enb", {5'b0, write_enb}, 8'h01);
      chk("rst_vld_out", {5'b0, vld_out}, 8'h02);
      chk("rst_addr_err", {7'b0, addr_err}, 8'h00);
      write_enb_reg = 1'b0;
      empty = '1;
      cyc();
      cyc();
      #2 reset = 1'b0;
      cyc();

      // Address steering; the detect cycle still uses the old address
      full = 3'b110;
      data_in = 2'b10;
      detect_add = 1'b1;
      write_enb_reg = 1'b1;
      #1;
      chk("steer_old_we", {5'b0, write_enb}, 8'h01);
      chk("steer_old_ff", {7'b0, fifo_full}, 8'h00);
      cyc();
      detect_add = 1'b0;
      #1;
      chk("steer_we", {5'b0, write_enb}, 8'h04);
      chk("steer_ff_full", {7'b0, fifo_full}, 8'h01);
      full = 3'b010;
      #1;
      chk("steer_ff_clear", {7'b0, fifo_full}, 8'h00);
      write_enb_reg = 1'b0;
      #1;
      chk("steer_we_off", {5'b0, write_enb}, 8'h00);

      // Invalid address
      full = '0;
      data_in = 2'b11;
      detect_add = 1'b1;
      cyc();
      detect_add = 1'b0;
      write_enb_reg = 1'b1;
      #1;
      chk("bad_addr_err", {7'b0, addr_err}, 8'h01);
      chk("bad_we", {5'b0, write_enb}, 8'h00);
      chk("bad_ff", {7'b0, fifo_full}, 8'h01);
      data_in = 2'b01;
      detect_add = 1'b1;
      cyc();
      detect_add = 1'b0;
      #1;
      chk("ch1_we", {5'b0, write_enb}, 8'h02);
      chk("ch1_addr_err", {7'b0, addr_err}, 8'h00);
      write_enb_reg = 1'b0;

      // Timeout on channel 0: pulses after edges 30 and 60
      empty = 3'b110;
      for (int k = 1; k <= 29; k++) begin
         cyc();
         chk("to_quiet1", {5'b0, soft_reset}, 8'h00);
      end
      cyc();
      chk("to_pulse30", {5'b0, soft_reset}, 8'h01);
      for (int k = 31; k <= 59; k++) begin
         cyc();
         chk("to_quiet2", {5'b0, soft_reset}, 8'h00);
      end
      cyc();
      chk("to_pulse60", {5'b0, soft_reset}, 8'h01);
      cyc();
      chk("to_after60", {5'b0, soft_reset}, 8'h00);
      empty = '1;
      cyc();
      cyc();

      // Read rescue on ch0 at the terminal cycle while ch2 times out
      empty = 3'b010;
      for (int k = 1; k <= 29; k++) begin
         cyc();
         chk("rescue_quiet1", {5'b0, soft_reset}, 8'h00);
      end
      read_enb = 3'b001;
      cyc();
      chk("rescue_edge30", {5'b0, soft_reset}, 8'h04);
      read_enb = '0;
      for (int k = 31; k <= 59; k++) begin
         cyc();
         chk("rescue_quiet2", {5'b0, soft_reset}, 8'h00);
      end
      cyc();
      chk("rescue_edge60", {5'b0, soft_reset}, 8'h05);
      empty = '1;
      cyc();
      cyc();

      // Reset mid-count on ch0 (address currently 1)
      empty = 3'b110;
      for (int k = 1; k <= 19; k++) cyc();
      #2 reset = 1'b1;
      #1;
      write_enb_reg = 1'b1;
      #1;
      chk("midrst_soft", {5'b0, soft_reset}, 8'h00);
      chk("midrst_we_addr0", {5'b0, write_enb}, 8'h01);
      chk("midrst_vld", {5'b0, vld_out}, 8'h01);
      write_enb_reg = 1'b0;
      cyc();
      cyc();
      chk("midrst_held", {5'b0, soft_reset}, 8'h00);
      #2 reset = 1'b0;
      for (int k = 1; k <= 29; k++) begin
         cyc();
         chk("midrst_quiet", {5'b0, soft_reset}, 8'h00);
      end
      cyc();
      chk("midrst_pulse30", {5'b0, soft_reset}, 8'h01);
      empty = '1;
      cyc();

      // Five-channel build: steering, addr_err, 4-cycle pulses
      full_b = 5'b10101;
      for (int a = 0; a < 8; a++) begin
         data_in_b = 3'(a);
         detect_add_b = 1'b1;
         write_enb_reg_b = 1'b0;
         cyc();
         detect_add_b = 1'b0;
         write_enb_reg_b = 1'b1;
         #1;
         exp_we  = (a < 5) ? (5'b00001 << a) : 5'b00000;
         exp_err = (a >= 5);
         exp_ff  = (a < 5) ? full_b[a] : 1'b1;
         chk("p_we", {3'b0, write_enb_b}, {3'b0, exp_we});
         chk("p_addr_err", {7'b0, addr_err_b}, {7'b0, exp_err});
         chk("p_ff", {7'b0, fifo_full_b}, {7'b0, exp_ff});
      end
      write_enb_reg_b = 1'b0;
      empty_b = 5'b11110;
      for (int r = 0; r < 2; r++) begin
         for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("p_quiet", {3'b0, soft_reset_b}, 8'h00);
         end
         cyc();
         chk("p_pulse", {3'b0, soft_reset_b}, 8'h01);
      end
      chk("p_other_quiet", {5'b0, soft_reset}, 8'h00);
      empty_b = '1;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/router_sync_n.md
ROUTER_SYNC_N -- requirements
Module: router_sync_n

Parameters
REQ-001 SHALL have NUM_CH, default 3, number of output channels, legal 2..8.
REQ-002 SHALL have ADDR_W, default $clog2(NUM_CH), width of the address field.
REQ-003 SHALL have TIMEOUT, default 30, idle-valid cycles before soft reset, legal 2..255.

Interface
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 data_in  in  ADDR_W  header address field.
REQ-007 detect_add  in  1  latch data_in as the active address this cycle.
REQ-008 write_enb_reg  in  1  FSM request to write the active channel FIFO.
REQ-009 read_enb  in  NUM_CH  per-channel read enable.
REQ-010 full  in  NUM_CH  per-channel FIFO full.
REQ-011 empty  in  NUM_CH  per-channel FIFO empty.
REQ-012 write_enb  out  NUM_CH  one-hot FIFO write enable.
REQ-013 fifo_full  out  1  full flag of the active channel.
REQ-014 vld_out  out  NUM_CH  per-channel data-valid.
REQ-015 soft_reset  out  NUM_CH  per-channel one-cycle timeout pulse.
REQ-016 addr_err  out  1  latched address is >= NUM_CH.

Function
REQ-017 Address register SHALL load data_in on the rising edge when detect_add=1 and hold otherwise.
- The cycle in which detect_add=1 SHALL still use the previously latched address.
REQ-018 write_enb SHALL be combinational.
- Bit [addr] = write_enb_reg when the address is valid.
- All bits SHALL be 0 when addr_err=1 or write_enb_reg=0.
- write_enb SHALL never have more than one bit set.
REQ-019 fifo_full SHALL be combinational: full[addr] when the address is valid, and 1 when addr_err=1, so the FSM stalls.
REQ-020 addr_err SHALL be combinational from the latched address.
- For power-of-two NUM_CH it SHALL be constant 0.
REQ-021 vld_out[i] SHALL be combinational ~empty[i].
REQ-022 Each channel SHALL have an independent idle counter, width $clog2(TIMEOUT+1).
- The counter SHALL clear whenever vld_out[i]=0 or read_enb[i]=1.
- It SHALL increment while vld_out[i]=1 and read_enb[i]=0.
REQ-023 When a counter reaches TIMEOUT-1 and is about to increment, it SHALL wrap to 0.
- soft_reset[i] SHALL be registered and assert for exactly one cycle on the following edge.
- First pulse: TIMEOUT cycles after vld_out rises, with no read.
- Further pulses: every TIMEOUT cycles while the condition persists.
REQ-024 read_enb[i]=1 in the same cycle as the terminal count SHALL clear the counter and suppress the pulse.
REQ-025 Channels SHALL not interact; simultaneous timeouts on several channels SHALL pulse together.
REQ-026 The address register SHALL be unaffected by soft_reset.

Reset
REQ-027 While reset=1, independent of clk:
- address register = 0.
- all counters = 0.
- soft_reset = 0.
REQ-028 During reset, combinational outputs SHALL follow their inputs:
- write_enb reflects address 0.
- vld_out = ~empty.
REQ-029 Reset asserted mid-count SHALL discard the count; after release, counting restarts from 0.

Structure
REQ-030 Package router_pkg SHALL hold:
- default constants ROUTER_NUM_CH=3, ROUTER_TIMEOUT=30.
- address-width helper.
REQ-031 Sub-module router_idle_timer, parameter TIMEOUT, SHALL implement one channel's counter and pulse.
- router_sync_n SHALL instantiate NUM_CH copies via generate.

Verification (NUM_CH=3, TIMEOUT=30 unless stated)
REQ-032 Address steering:
- Stimulus: data_in=2'b10 with detect_add=1 for one cycle, then write_enb_reg=1.
- Response: write_enb=3'b100; fifo_full tracks full[2].
REQ-033 Invalid address:
- Stimulus: data_in=2'b11, detect_add=1, then write_enb_reg=1.
- Response: addr_err=1, write_enb=3'b000, fifo_full=1.
REQ-034 Timeout:
- Stimulus: empty[0] falls, read_enb[0]=0 held.
- Response: soft_reset[0] pulses once at cycle 30, again at cycle 60; other bits stay 0.
REQ-035 Read rescue:
- Stimulus: same as REQ-034, with read_enb[0]=1 at cycle 29.
- Response: no pulse; counter restarts.
REQ-036 Reset mid-count:
- Stimulus: reset pulse at cycle 20 of a timeout.
- Response: outputs cleared asynchronously; first pulse at 30 cycles after release.
REQ-037 Parametric run:
- Configuration: NUM_CH=5, TIMEOUT=4.
- Response: addresses 0..4 steer correctly; 5..7 raise addr_err; pulses occur every 4 cycles.
